// File: rtl/fifo_wptr_full.sv
// Write-side pointer, full/almost-full and occupancy logic for the async FIFO.
// Consumes the read pointer already synchronized into clk_i.
module fifo_wptr_full #(
    parameter int PTR_WIDTH = 4,
    parameter int AF_THRESH = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 wr_en_i,
    input  logic                 clr_ovf_i,
    input  logic [PTR_WIDTH:0]   rptr_sync_i,
    output logic [PTR_WIDTH-1:0] waddr_o,
    output logic                 wr_accept_o,
    output logic [PTR_WIDTH:0]   wptr_gray_o,
    output logic                 full_o,
    output logic                 almost_full_o,
    output logic [PTR_WIDTH:0]   wr_count_o,
    output logic                 overflow_o
);

    localparam int PW = PTR_WIDTH + 1;
    localparam logic [PTR_WIDTH:0] AF_LIMIT = PW'((2 ** PTR_WIDTH) - AF_THRESH);

    logic [PTR_WIDTH:0] r_wbin;
    logic [PTR_WIDTH:0] r_wgray;
    logic [PTR_WIDTH:0] r_count;
    logic               r_full;
    logic               r_af;
    logic               r_ovf;

    logic               w_accept;
    logic [PTR_WIDTH:0] w_wbin_next;
    logic [PTR_WIDTH:0] w_wgray_next;
    logic [PTR_WIDTH:0] w_rbin;
    logic [PTR_WIDTH:0] w_rgray_full;
    logic [PTR_WIDTH:0] w_count_next;
    logic               w_full_next;
    logic               w_af_next;
    logic               w_ovf_next;

    assign w_accept     = wr_en_i & ~r_full;
    assign w_wbin_next  = r_wbin + {{PTR_WIDTH{1'b0}}, w_accept};
    assign w_wgray_next = w_wbin_next ^ (w_wbin_next >> 1);

    // Each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        w_rbin = '0;
        for (int i = 0; i < PW; i++) begin
            w_rbin[i] = ^(rptr_sync_i >> i);
        end
    end

    // Full when the pointers differ only in the wrap bit (top two Gray bits).
    assign w_rgray_full = {~rptr_sync_i[PTR_WIDTH:PTR_WIDTH-1],
                           rptr_sync_i[PTR_WIDTH-2:0]};
    assign w_full_next  = (w_wgray_next == w_rgray_full);
    assign w_count_next = w_wbin_next - w_rbin;
    assign w_af_next    = (w_count_next >= AF_LIMIT);

    always_comb begin
        w_ovf_next = r_ovf;
        if (wr_en_i && r_full) begin
            w_ovf_next = 1'b1;
        end else if (clr_ovf_i) begin
            w_ovf_next = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_wbin  <= '0;
            r_wgray <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
            r_af    <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_wbin  <= w_wbin_next;
            r_wgray <= w_wgray_next;
            r_count <= w_count_next;
            r_full  <= w_full_next;
            r_af    <= w_af_next;
            r_ovf   <= w_ovf_next;
        end
    end

    assign waddr_o       = r_wbin[PTR_WIDTH-1:0];
    assign wr_accept_o   = w_accept;
    assign wptr_gray_o   = r_wgray;
    assign full_o        = r_full;
    assign almost_full_o = r_af;
    assign wr_count_o    = r_count;
    assign overflow_o    = r_ovf;

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Self-checking bench for fifo_wptr_full (PTR_WIDTH=4, AF_THRESH=2).
// Reference model tracks occupancy as an integer; registered results go through a queue.
module tb_fifo_wptr_full;

    logic       clk_i;
    logic       rst_n_i;
    logic       wr_en_i;
    logic       clr_ovf_i;
    logic [4:0] rptr_sync_i;
    logic [3:0] waddr_o;
    logic       wr_accept_o;
    logic [4:0] wptr_gray_o;
    logic       full_o;
    logic       almost_full_o;
    logic [4:0] wr_count_o;
    logic       overflow_o;

    fifo_wptr_full #(.PTR_WIDTH(4), .AF_THRESH(2)) dut (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .wr_en_i      (wr_en_i),
        .clr_ovf_i    (clr_ovf_i),
        .rptr_sync_i  (rptr_sync_i),
        .waddr_o      (waddr_o),
        .wr_accept_o  (wr_accept_o),
        .wptr_gray_o  (wptr_gray_o),
        .full_o       (full_o),
        .almost_full_o(almost_full_o),
        .wr_count_o   (wr_count_o),
        .overflow_o   (overflow_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [4:0] gray;
        logic       full;
        logic       af;
        logic [4:0] cnt;
        logic       ovf;
    } exp_t;

    typedef struct {
        logic       wr;
        logic       clr;
        logic [4:0] rd;
        logic       acc;
        logic       full;
        logic       af;
        logic [4:0] cnt;
        logic       ovf;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[8];

    int tests;
    int fails;

    int         m_wbin;
    logic       m_full;
    logic       m_af;
    int         m_cnt;
    logic       m_ovf;
    logic       last_acc;
    logic [4:0] prev_gray;

    function automatic logic [4:0] to_gray(input int b);
        logic [4:0] v;
        v = 5'(b);
        return v ^ (v >> 1);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_wbin = 0;
        m_full = 1'b0;
        m_af   = 1'b0;
        m_cnt  = 0;
        m_ovf  = 1'b0;
        sb.delete();
    endtask

    // One clock: drive on negedge, check combinational outputs, predict, check after posedge.
    task automatic step(input logic wr, input logic clr, input int rd_bin);
        exp_t e;
        exp_t got;
        int   nb;
        @(negedge clk_i);
        wr_en_i     = wr;
        clr_ovf_i   = clr;
        rptr_sync_i = to_gray(rd_bin);
        #1;
        last_acc = wr & ~m_full;
        chk("wr_accept", int'(wr_accept_o), int'(last_acc));
        chk("waddr", int'(waddr_o), m_wbin % 16);
        nb    = (m_wbin + int'(last_acc)) % 32;
        m_cnt = (nb - (rd_bin % 32) + 32) % 32;
        m_ovf = (wr && m_full) ? 1'b1 : (clr ? 1'b0 : m_ovf);
        m_full = (m_cnt == 16);
        m_af   = (m_cnt >= 14);
        m_wbin = nb;
        e.gray = to_gray(nb);
        e.full = m_full;
        e.af   = m_af;
        e.cnt  = 5'(m_cnt);
        e.ovf  = m_ovf;
        sb.push_back(e);
        prev_gray = wptr_gray_o;
        @(posedge clk_i);
        #1;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 1, 0);
        end else begin
            got = sb.pop_front();
            chk("wptr_gray", int'(wptr_gray_o), int'(got.gray));
            chk("full", int'(full_o), int'(got.full));
            chk("almost_full", int'(almost_full_o), int'(got.af));
            chk("wr_count", int'(wr_count_o), int'(got.cnt));
            chk("overflow", int'(overflow_o), int'(got.ovf));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic seen_wrap;
        logic [3:0] prev_addr;
        tests = 0;
        fails = 0;

        vecs[0] = '{wr:1, clr:0, rd:0, acc:0, full:1, af:1, cnt:16, ovf:1};
        vecs[1] = '{wr:0, clr:0, rd:0, acc:0, full:1, af:1, cnt:16, ovf:1};
        vecs[2] = '{wr:1, clr:1, rd:0, acc:0, full:1, af:1, cnt:16, ovf:1};
        vecs[3] = '{wr:0, clr:1, rd:0, acc:0, full:1, af:1, cnt:16, ovf:0};
        vecs[4] = '{wr:0, clr:0, rd:1, acc:0, full:0, af:1, cnt:15, ovf:0};
        vecs[5] = '{wr:1, clr:0, rd:1, acc:1, full:1, af:1, cnt:16, ovf:0};
        vecs[6] = '{wr:0, clr:0, rd:3, acc:0, full:0, af:1, cnt:14, ovf:0};
        vecs[7] = '{wr:0, clr:0, rd:5, acc:0, full:0, af:0, cnt:12, ovf:0};

        wr_en_i     = 1'b0;
        clr_ovf_i   = 1'b0;
        rptr_sync_i = '0;
        rst_n_i     = 1'b0;
        model_reset();
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_gray", int'(wptr_gray_o), 0);
        chk("rst_full", int'(full_o), 0);
        chk("rst_af", int'(almost_full_o), 0);
        chk("rst_cnt", int'(wr_count_o), 0);
        chk("rst_ovf", int'(overflow_o), 0);
        chk("rst_waddr", int'(waddr_o), 0);
        @(negedge clk_i);
        rst_n_i = 1'b1;

        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b0, 0);
            chk("fill_accept", int'(last_acc), 1);
        end
        chk("fill_gray", int'(wptr_gray_o), 5'b11000);
        chk("fill_full", int'(full_o), 1);
        chk("fill_cnt", int'(wr_count_o), 16);

        for (int i = 0; i < 8; i++) begin
            step(vecs[i].wr, vecs[i].clr, int'(vecs[i].rd));
            chk($sformatf("vec%0d_acc", i), int'(last_acc), int'(vecs[i].acc));
            chk($sformatf("vec%0d_full", i), int'(full_o), int'(vecs[i].full));
            chk($sformatf("vec%0d_af", i), int'(almost_full_o), int'(vecs[i].af));
            chk($sformatf("vec%0d_cnt", i), int'(wr_count_o), int'(vecs[i].cnt));
            chk($sformatf("vec%0d_ovf", i), int'(overflow_o), int'(vecs[i].ovf));
        end
        chk("dropped_hold_gray", int'(wptr_gray_o), int'(to_gray(17)));

        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 5);
        @(negedge clk_i);
        #2;
        rst_n_i = 1'b0;
        #1;
        chk("async_rst_gray", int'(wptr_gray_o), 0);
        chk("async_rst_full", int'(full_o), 0);
        chk("async_rst_af", int'(almost_full_o), 0);
        chk("async_rst_cnt", int'(wr_count_o), 0);
        chk("async_rst_ovf", int'(overflow_o), 0);
        chk("async_rst_waddr", int'(waddr_o), 0);
        model_reset();
        @(posedge clk_i);
        #1;
        rst_n_i = 1'b1;

        for (int i = 0; i < 13; i++) step(1'b1, 1'b0, 0);
        chk("af13_af", int'(almost_full_o), 0);
        chk("af13_cnt", int'(wr_count_o), 13);
        step(1'b1, 1'b0, 0);
        chk("af14_af", int'(almost_full_o), 1);
        chk("af14_cnt", int'(wr_count_o), 14);

        seen_wrap = 1'b0;
        for (int i = 0; i < 40; i++) begin
            prev_addr = 4'(m_wbin);
            step(1'b1, 1'b0, (m_wbin + 30) % 32);
            chk("wrap_onebit", $countones(wptr_gray_o ^ prev_gray), int'(last_acc));
            chk("wrap_nofull", int'(full_o), 0);
            if (prev_addr == 4'd15 && last_acc) seen_wrap = 1'b1;
        end
        chk("waddr_wrapped", int'(seen_wrap), 1);
        chk("wrap_waddr_final", int'(waddr_o), m_wbin % 16);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fifo_wptr_full.md
Name: fifo_wptr_full

Overview:
- Write-domain pointer and flag generator for the asynchronous FIFO; it produces the Gray-coded write pointer that the read domain's 2-flop synchronizer receives.
- It consumes the read pointer after that pointer has been synchronized into the write clock domain.
- Outputs: write address, registered Gray write pointer, full / almost-full flags, occupancy count, sticky overflow flag.
- Sits between the write client, the dual-port RAM write port, and the two cross-domain synchronizers.

Parameters:
- PTR_WIDTH, 4, address width; FIFO depth = 2**PTR_WIDTH; pointers are PTR_WIDTH+1 bits; legal range >= 2.
- AF_THRESH, 2, almost_full_o asserts when free slots <= AF_THRESH; legal range 0 .. 2**PTR_WIDTH-1.

Ports:
- clk_i  input  1  write-domain clock.
- rst_n_i  input  1  reset, asynchronous, active-low.
- wr_en_i  input  1  write request from client.
- clr_ovf_i  input  1  clears sticky overflow flag.
- rptr_sync_i  input  PTR_WIDTH+1  Gray read pointer, already synchronized to clk_i.
- waddr_o  output  PTR_WIDTH  RAM write address.
- wr_accept_o  output  1  write accepted this cycle (RAM write enable).
- wptr_gray_o  output  PTR_WIDTH+1  registered Gray write pointer, to read-domain synchronizer.
- full_o  output  1  FIFO full.
- almost_full_o  output  1  free slots <= AF_THRESH.
- wr_count_o  output  PTR_WIDTH+1  occupancy as seen from the write domain.
- overflow_o  output  1  sticky: write attempted while full.

Behaviour:
- State registers: binary write pointer wbin, wptr_gray_o, full_o, almost_full_o, wr_count_o, overflow_o.
- Reset (async, rst_n_i=0): all of these registers are 0. Reset mid-operation returns them to 0 immediately, regardless of the clock.
- wr_accept_o = wr_en_i & ~full_o. This is combinational and uses the registered full flag.
- waddr_o = wbin[PTR_WIDTH-1:0], i.e. the address for the current accepted write.
- wbin_next = wbin + wr_accept_o, modulo 2**(PTR_WIDTH+1). Wrap from all-ones to 0 is natural.
- wgray_next = wbin_next ^ (wbin_next >> 1). wptr_gray_o is registered from wgray_next.
- wptr_gray_o must change at most one bit per clock; no combinational path may drive it.
- Full test: full_next = (wgray_next == {~rptr_sync_i[PTR_WIDTH:PTR_WIDTH-1], rptr_sync_i[PTR_WIDTH-2:0]}), registered into full_o.
- full_o asserts on the cycle following the accepted write that fills the FIFO.
- Full is pessimistic: it deasserts only after the read pointer update has crossed the synchronizer.
- Occupancy: rbin = Gray-to-binary of rptr_sync_i (MSB copied, then XOR cascade). wr_count_o is registered from (wbin_next - rbin) modulo 2**(PTR_WIDTH+1).
- Range of wr_count_o is 0 .. 2**PTR_WIDTH.
- almost_full_o is registered from (count_next >= 2**PTR_WIDTH - AF_THRESH). With AF_THRESH=0 it equals full.
- Overflow:
  - overflow_o sets when wr_en_i=1 and full_o=1.
  - clr_ovf_i clears it.
  - Simultaneous set and clear: set wins.
  - A write request while full is dropped: no pointer or address change, wr_accept_o=0.
- A stale or non-advancing rptr_sync_i must never produce a false non-full indication.
- An rptr_sync_i that moves by several steps between cycles is handled in a single cycle.

Test Plan:
- Reset, then 16 consecutive writes with rptr_sync_i=0 (PTR_WIDTH=4) -> wr_accept_o high for all 16; waddr_o steps 0..15; full_o=1 the cycle after the 16th write; wptr_gray_o=5'b11000; wr_count_o=16.
- Hold full, pulse wr_en_i -> wr_accept_o=0, wptr_gray_o unchanged, overflow_o=1 and it stays 1; assert clr_ovf_i and wr_en_i together -> overflow_o stays 1; clr_ovf_i alone -> overflow_o=0.
- From full, set rptr_sync_i=5'b00001 -> full_o=0 the next cycle; wr_count_o=15; almost_full_o=1.
- Almost-full boundary: write 13 entries with rptr_sync_i=0 -> almost_full_o=0; 14th write -> almost_full_o=1 next cycle, wr_count_o=14.
- Wrap-around: 40 writes, with rptr_sync_i tracking the Gray of (written-2) each cycle -> no full; wptr_gray_o sequence shows exactly one bit change per accepted write across the 31->0 wrap; waddr_o wraps 15->0.
- Assert rst_n_i low mid-burst, asynchronously between clock edges -> all outputs 0 immediately; the first write after release uses waddr_o=0.
